// File: rtl/gate_op_arbiter.sv
// gate_op_arbiter: round-robin arbiter in front of one shared single-bit gate unit.
// Each requester presents a 3-bit opcode and two operand bits. The arbiter grants
// one requester, evaluates its operation, then holds the result until the consumer
// accepts it.
// Optional statistics counter: define GATE_OP_ARBITER_STATS_EN to add res_count.

module mux2x1 (
    input  logic sel,
    input  logic i0,
    input  logic i1,
    output logic out
);
    assign out = sel ? i1 : i0;
endmodule

module gate_op_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [NREQ-1:0]   req_a,
    input  logic [NREQ-1:0]   req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_data,
    output logic [IDW-1:0]    res_id
`ifdef GATE_OP_ARBITER_STATS_EN
    ,
    output logic [7:0]        res_count
`endif
);

    typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;

    logic            any_req;
    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] win_oh;
    logic [2:0]      win_op;
    logic            win_a;
    logic            win_b;

    logic [2:0]      op_p0;
    logic            a_p0;
    logic            b_p0;
    logic [IDW-1:0]  id_p0;

    // Round-robin search from rr_ptr, then select the winner's opcode and operands
    always_comb begin
        int idx;
        idx     = 0;
        any_req = 1'b0;
        win_id  = '0;
        win_oh  = '0;
        win_op  = 3'd0;
        win_a   = 1'b0;
        win_b   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            for (int i = 0; i < NREQ; i++) begin
                if (!any_req && (i == idx) && req_valid[i]) begin
                    any_req   = 1'b1;
                    win_id    = IDW'(i);
                    win_oh[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (any_req && (win_id == IDW'(i))) begin
                win_op = req_op[3*i +: 3];
                win_a  = req_a[i];
                win_b  = req_b[i];
            end
        end
    end

    // The accept strobe is only offered while idle and out of reset, so a requester
    // never sees a handshake that the FSM does not actually take
    assign req_ready = (state == IDLE && !rst) ? win_oh : '0;

    // Shared gate unit: every function and inversion is a mux2x1
    logic n_a, n_b, g_and, g_or, g_xor, g_nand, g_nor, g_xnor;
    logic m0, m1, m2, m3, m01, m23, gate_out;

    mux2x1 u_na   (.sel(a_p0),  .i0(1'b1), .i1(1'b0), .out(n_a));
    mux2x1 u_nb   (.sel(b_p0),  .i0(1'b1), .i1(1'b0), .out(n_b));
    mux2x1 u_and  (.sel(a_p0),  .i0(1'b0), .i1(b_p0), .out(g_and));
    mux2x1 u_or   (.sel(a_p0),  .i0(b_p0), .i1(1'b1), .out(g_or));
    mux2x1 u_xor  (.sel(a_p0),  .i0(b_p0), .i1(n_b),  .out(g_xor));
    mux2x1 u_nand (.sel(g_and), .i0(1'b1), .i1(1'b0), .out(g_nand));
    mux2x1 u_nor  (.sel(g_or),  .i0(1'b1), .i1(1'b0), .out(g_nor));
    mux2x1 u_xnor (.sel(g_xor), .i0(1'b1), .i1(1'b0), .out(g_xnor));

    // 8:1 opcode select tree: op[0] picks within each pair, op[2:1] picks the pair
    mux2x1 u_m0   (.sel(op_p0[0]), .i0(a_p0),   .i1(n_a),    .out(m0));
    mux2x1 u_m1   (.sel(op_p0[0]), .i0(g_and),  .i1(g_or),   .out(m1));
    mux2x1 u_m2   (.sel(op_p0[0]), .i0(g_nand), .i1(g_nor),  .out(m2));
    mux2x1 u_m3   (.sel(op_p0[0]), .i0(g_xor),  .i1(g_xnor), .out(m3));
    mux2x1 u_m01  (.sel(op_p0[1]), .i0(m0),     .i1(m1),     .out(m01));
    mux2x1 u_m23  (.sel(op_p0[1]), .i0(m2),     .i1(m3),     .out(m23));
    mux2x1 u_mout (.sel(op_p0[2]), .i0(m01),    .i1(m23),    .out(gate_out));

    // Operand capture at grant; later input changes cannot disturb the operation
    always_ff @(posedge clk) begin
        if (state == IDLE && any_req) begin
            op_p0 <= win_op;
            a_p0  <= win_a;
            b_p0  <= win_b;
            id_p0 <= win_id;
        end
    end

    // Control FSM with registered result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            res_valid <= 1'b0;
            res_data  <= 1'b0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state  <= EVAL;
                        rr_ptr <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + IDW'(1);
                    end
                end
                EVAL: begin
                    res_valid <= 1'b1;
                    res_data  <= gate_out;
                    res_id    <= id_p0;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_OP_ARBITER_STATS_EN
    // Completed-handshake counter, saturating at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            res_count <= 8'd0;
        end else if (res_valid && res_ready && (res_count != 8'hFF)) begin
            res_count <= res_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed testbench for gate_op_arbiter (NREQ=4). Inputs are driven on the falling
// edge and outputs are sampled 1 time unit later.
// Define GATE_OP_ARBITER_STATS_EN to also exercise res_count.

module tb_gate_op_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [3*NREQ-1:0] req_op;
    logic [NREQ-1:0]   req_a;
    logic [NREQ-1:0]   req_b;
    logic              res_valid;
    logic              res_ready;
    logic              res_data;
    logic [IDW-1:0]    res_id;
`ifdef GATE_OP_ARBITER_STATS_EN
    logic [7:0]        res_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    gate_op_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
`ifdef GATE_OP_ARBITER_STATS_EN
        ,
        .res_count (res_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic ref_gate(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0:    ref_gate = a;
            3'd1:    ref_gate = ~a;
            3'd2:    ref_gate = a & b;
            3'd3:    ref_gate = a | b;
            3'd4:    ref_gate = ~(a & b);
            3'd5:    ref_gate = ~(a | b);
            3'd6:    ref_gate = a ^ b;
            default: ref_gate = ~(a ^ b);
        endcase
    endfunction

    task automatic set_req(input int id, input logic [2:0] op, input logic a, input logic b);
        req_op[3*id +: 3] = op;
        req_a[id] = a;
        req_b[id] = b;
    endtask

    function automatic logic [31:0] onehot(input int id);
        logic [31:0] v;
        v = 32'd1 << id;
        return v;
    endfunction

    // One complete operation from IDLE with res_ready held high
    task automatic run_op(input int id, input logic [2:0] op, input logic a, input logic b);
        @(negedge clk);
        set_req(id, op, a, b);
        req_valid = NREQ'(onehot(id));
        #1 chk("grant", 32'(req_ready), onehot(id));
        @(negedge clk);
        req_valid = '0;
        #1 chk("eval_ready", 32'(req_ready), 32'd0);
        chk("eval_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        #1 chk("res_valid", 32'(res_valid), 32'd1);
        chk("res_data", 32'(res_data), 32'(ref_gate(op, a, b)));
        chk("res_id", 32'(res_id), 32'(id));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] ab;
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;

        // Reset state, including the strobe being suppressed while rst is high
        repeat (2) @(negedge clk);
        req_valid = 4'hF;
        #1 chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = '0;
        #1 chk("idle_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1 chk("idle_ready2", 32'(req_ready), 32'd0);
        chk("idle_valid", 32'(res_valid), 32'd0);

        // Single request: AND(1,1) on requester 0, result two cycles after grant
        run_op(0, 3'd2, 1'b1, 1'b1);
        @(negedge clk);
        #1 chk("single_clear", 32'(res_valid), 32'd0);

        // Every opcode with every operand pair on requester 2
        for (int op = 0; op < 8; op++) begin
            for (int k = 0; k < 4; k++) begin
                ab = 2'(k);
                run_op(2, 3'(op), ab[1], ab[0]);
            end
        end

        // Round robin with all requesters held valid
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i + 2), 1'b1, 1'b0);
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            int w;
            w = 0;
            while (req_ready == '0 && w < 8) begin
                @(negedge clk);
                #1;
                w++;
            end
            chk("rr_grant", 32'(req_ready), onehot(g % 4));
            @(negedge clk);
            #1;
        end
        // Now in EVAL of requester 0's operation; rr_ptr has moved to 1
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);

        // Backpressure, plus a waiting requester that withdraws before its grant
        res_ready = 1'b0;
        set_req(1, 3'd4, 1'b1, 1'b1);
        req_valid = 4'b0010;
        #1 chk("bp_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        set_req(2, 3'd3, 1'b1, 1'b1);
        req_valid = 4'b0100;
        #1 chk("bp_eval_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_valid0", 32'(res_valid), 32'd1);
        chk("bp_data0", 32'(res_data), 32'd0);
        chk("bp_id0", 32'(res_id), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) begin
                set_req(3, 3'd6, 1'b1, 1'b0);
                req_valid = 4'b1000;
            end
            #1 chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_data", 32'(res_data), 32'd0);
            chk("bp_id", 32'(res_id), 32'd1);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        res_ready = 1'b1;
        #1 chk("bp_release_valid", 32'(res_valid), 32'd1);
        chk("bp_release_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1 chk("bp_next_grant", 32'(req_ready), 32'h8);
        chk("bp_valid_clear", 32'(res_valid), 32'd0);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 chk("bp_next_valid", 32'(res_valid), 32'd1);
        chk("bp_next_data", 32'(res_data), 32'd1);
        chk("bp_next_id", 32'(res_id), 32'd3);

        // Reset during EVAL discards the operation and rewinds rr_ptr
        @(negedge clk);
        set_req(2, 3'd3, 1'b0, 1'b1);
        req_valid = 4'b0100;
        #1 chk("mid_grant", 32'(req_ready), 32'h4);
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1 chk("mid_valid", 32'(res_valid), 32'd0);
        @(negedge clk);
        set_req(0, 3'd7, 1'b0, 1'b0);
        set_req(3, 3'd1, 1'b0, 1'b0);
        req_valid = 4'b1001;
        #1 chk("mid_valid2", 32'(res_valid), 32'd0);
        chk("mid_rr_reset", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 chk("mid_res_id0", 32'(res_id), 32'd0);
        chk("mid_res_data0", 32'(res_data), 32'd1);
        @(negedge clk);
        req_valid = 4'b1000;
        #1 chk("mid_grant3", 32'(req_ready), 32'h8);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 chk("mid_res_id3", 32'(res_id), 32'd3);
        chk("mid_res_data3", 32'(res_data), 32'd1);

`ifdef GATE_OP_ARBITER_STATS_EN
        // Saturating statistics counter
        do_reset();
        #1 chk("cnt_reset0", 32'(res_count), 32'd0);
        req_valid = 4'hF;
        repeat (905) @(negedge clk);
        #1 chk("cnt_sat", 32'(res_count), 32'd255);
        req_valid = '0;
        do_reset();
        #1 chk("cnt_reset1", 32'(res_count), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
